stb_host_adapter: RTL and testbench

//  Host-side front end of the streaming trace buffer. Converts a byte stream from the host link
//  (UART/JTAG byte bridge) into word-wide write and read bursts on the buffer's system-side

---
 rtl/stb_pkg.sv | 29 ++
 rtl/stb_word_serializer.sv | 65 ++++++
 rtl/stb_host_adapter.sv | 204 ++++++++++++++++++++
 tb/tb_stb_host_adapter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
// Shared types for the streaming trace buffer host adapter.
// Holds the command byte layout, the adapter FSM state encoding and a small
// width helper used by the top level and the read-path serializer.
package stb_pkg;

    localparam int CMD_COUNT_W = 6;

    // Host command byte: bit 7 direction, bit 6 register select, bits 5:0 words-1.
    typedef struct packed {
        logic                   write;
        logic                   reg_sel;
        logic [CMD_COUNT_W-1:0] count;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_ISSUE,
        WR_ACK,
        RD_WAIT,
        RD_SEND
    } adapter_state_e;

    // Byte index width for a word of nb bytes; never narrower than one bit.
    function automatic int idx_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/stb_word_serializer.sv
// Read-path word-to-byte serializer.
// Accepts one DATA_W word when empty, then presents its bytes LSB first on a
// ready-valid byte port. out_last_o flags the final byte of the word so the
// owner can tell when the word has fully drained.
module stb_word_serializer
    import stb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = idx_width(NB);

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;

    assign in_ready_o  = !valid_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = 8'(word_q >> {idx_q, 3'b000});
    assign out_last_o  = (idx_q == IDX_W'(NB - 1));

    // Load a word when empty; step through its bytes on each output handshake.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (in_valid_i && in_ready_o) begin
            word_d  = in_data_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            if (out_last_o) begin
                idx_d   = '0;
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/stb_host_adapter.sv
// Host-side front end of the streaming trace buffer.
// Turns a host byte stream into word write/read bursts on the buffer's
// ready-valid port and returns read words to the host as bytes, LSB first.
// Optional build macro STB_HOST_ADAPTER_ACK_EN: after the final write of a
// burst the original command byte is echoed to the host as an acknowledge.
module stb_host_adapter
    import stb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK_I,
    input  logic              RST_NI,
    input  logic [7:0]        RX_DATA_I,
    input  logic              RX_VALID_I,
    output logic              RX_READY_O,
    output logic [7:0]        TX_DATA_O,
    output logic              TX_VALID_O,
    input  logic              TX_READY_I,
    output logic              REG_SELECT_O,
    output logic [DATA_W-1:0] WRITE_DATA_O,
    output logic              WRITE_VALID_O,
    input  logic              WRITE_READY_I,
    input  logic [DATA_W-1:0] READ_DATA_I,
    input  logic              READ_VALID_I,
    output logic              READ_READY_O
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = idx_width(NB);

    adapter_state_e         state_q, state_d;
    logic [CMD_COUNT_W-1:0] words_left_q, words_left_d;
    logic [IDX_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   reg_sel_q, reg_sel_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   wr_valid_q, wr_valid_d;
    logic                   rd_ready_q, rd_ready_d;
`ifdef STB_HOST_ADAPTER_ACK_EN
    cmd_t                   cmd_q, cmd_d;
    logic                   ack_valid_q, ack_valid_d;
`endif

    cmd_t       rx_cmd;
    logic       rx_fire;
    logic       wr_fire;
    logic       rd_fire;
    logic       byte_last;
    logic       ser_in_ready;
    logic [7:0] ser_out_data;
    logic       ser_out_valid;
    logic       ser_out_last;

    assign rx_cmd    = cmd_t'(RX_DATA_I);
    assign rx_fire   = RX_VALID_I && rx_ready_q;
    assign wr_fire   = wr_valid_q && WRITE_READY_I;
    assign rd_fire   = (state_q == RD_WAIT) && READ_VALID_I && rd_ready_q && ser_in_ready;
    assign byte_last = (byte_cnt_q == IDX_W'(NB - 1));

    stb_word_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk         (CLK_I),
        .rst_n       (RST_NI),
        .in_data_i   (READ_DATA_I),
        .in_valid_i  (rd_fire),
        .in_ready_o  (ser_in_ready),
        .out_data_o  (ser_out_data),
        .out_valid_o (ser_out_valid),
        .out_ready_i (TX_READY_I),
        .out_last_o  (ser_out_last)
    );

    // Next-state logic; the handshake outputs are decoded from the next state
    // so they are registered and line up with the state they belong to.
    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        state_d      = state_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        wdata_d      = wdata_q;
        reg_sel_d    = reg_sel_q;
`ifdef STB_HOST_ADAPTER_ACK_EN
        cmd_d        = cmd_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    reg_sel_d    = rx_cmd.reg_sel;
                    words_left_d = rx_cmd.count;
                    byte_cnt_d   = '0;
                    state_d      = rx_cmd.write ? WR_COLLECT : RD_WAIT;
`ifdef STB_HOST_ADAPTER_ACK_EN
                    cmd_d        = rx_cmd;
`endif
                end
            end
            WR_COLLECT: begin
                if (rx_fire) begin
                    // Shift right so the first byte of the word ends up in bits 7:0.
                    wdata_d = (wdata_q >> 8) | (DATA_W'(RX_DATA_I) << (DATA_W - 8));
                    if (byte_last) begin
                        byte_cnt_d = '0;
                        state_d    = WR_ISSUE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            WR_ISSUE: begin
                if (wr_fire) begin
                    if (words_left_q == '0) begin
`ifdef STB_HOST_ADAPTER_ACK_EN
                        state_d = WR_ACK;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        words_left_d = words_left_q - 1'b1;
                        state_d      = WR_COLLECT;
                    end
                end
            end
`ifdef STB_HOST_ADAPTER_ACK_EN
            WR_ACK: begin
                if (ack_valid_q && TX_READY_I) begin
                    state_d = IDLE;
                end
            end
`endif
            RD_WAIT: begin
                if (rd_fire) begin
                    state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                if (ser_out_valid && TX_READY_I && ser_out_last) begin
                    if (words_left_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        words_left_d = words_left_q - 1'b1;
                        state_d      = RD_WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d  = (state_d == IDLE) || (state_d == WR_COLLECT);
        wr_valid_d  = (state_d == WR_ISSUE);
        rd_ready_d  = (state_d == RD_WAIT);
`ifdef STB_HOST_ADAPTER_ACK_EN
        ack_valid_d = (state_d == WR_ACK);
`endif
    end

    // State and registered-output flops; reset aborts any burst in progress.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        // NOTE: non-blocking assignments let every flop sample the pre-edge values of the others.
        if (!RST_NI) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            wdata_q      <= '0;
            reg_sel_q    <= 1'b0;
            rx_ready_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_ready_q   <= 1'b0;
`ifdef STB_HOST_ADAPTER_ACK_EN
            cmd_q        <= '0;
            ack_valid_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            wdata_q      <= wdata_d;
            reg_sel_q    <= reg_sel_d;
            rx_ready_q   <= rx_ready_d;
            wr_valid_q   <= wr_valid_d;
            rd_ready_q   <= rd_ready_d;
`ifdef STB_HOST_ADAPTER_ACK_EN
            cmd_q        <= cmd_d;
            ack_valid_q  <= ack_valid_d;
`endif
        end
    end

    assign RX_READY_O    = rx_ready_q;
    assign REG_SELECT_O  = reg_sel_q;
    assign WRITE_DATA_O  = wdata_q;
    assign WRITE_VALID_O = wr_valid_q;
    assign READ_READY_O  = rd_ready_q;
`ifdef STB_HOST_ADAPTER_ACK_EN
    assign TX_VALID_O    = ser_out_valid || ack_valid_q;
    assign TX_DATA_O     = ack_valid_q ? 8'(cmd_q) : ser_out_data;
`else
    assign TX_VALID_O    = ser_out_valid;
    assign TX_DATA_O     = ser_out_data;
`endif

endmodule

// File: tb/tb_stb_host_adapter.sv
// Directed testbench for stb_host_adapter (DATA_W = 32).
// Define STB_HOST_ADAPTER_ACK_EN for both bench and RTL to cover the
// write-acknowledge build.
module tb_stb_host_adapter;

    localparam int DATA_W = 32;
    localparam int LIMIT  = 1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              reg_select;
    logic [DATA_W-1:0] write_data;
    logic              write_valid;
    logic              write_ready;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              read_ready;

    int checks = 0;
    int errors = 0;
    int tx_mode = 0;   // 0: TX ready always, 1: toggle every cycle

    logic [DATA_W-1:0] wr_q[$];
    logic [7:0]        tx_q[$];

    logic              wr_wait_prev = 1'b0;
    logic [DATA_W-1:0] wr_data_prev = '0;
    logic              tx_wait_prev = 1'b0;
    logic [7:0]        tx_data_prev = '0;

    stb_host_adapter #(.DATA_W(DATA_W)) dut (
        .CLK_I         (clk),
        .RST_NI        (rst_n),
        .RX_DATA_I     (rx_data),
        .RX_VALID_I    (rx_valid),
        .RX_READY_O    (rx_ready),
        .TX_DATA_O     (tx_data),
        .TX_VALID_O    (tx_valid),
        .TX_READY_I    (tx_ready),
        .REG_SELECT_O  (reg_select),
        .WRITE_DATA_O  (write_data),
        .WRITE_VALID_O (write_valid),
        .WRITE_READY_I (write_ready),
        .READ_DATA_I   (read_data),
        .READ_VALID_I  (read_valid),
        .READ_READY_O  (read_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        errors++;
        $error("FAIL %s: timed out after %0d cycles", tag, LIMIT);
    endtask

    // TX ready pattern generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_mode == 1) tx_ready = ~tx_ready;
            else              tx_ready = 1'b1;
        end
    end

    // Handshake capture, hold-stability and read-ready exclusion checks.
    always @(negedge clk) begin
        if (rst_n && wr_wait_prev) begin
            check("wr_hold_valid", write_valid, 1);
            check("wr_hold_data", write_data, wr_data_prev);
        end
        if (rst_n && tx_wait_prev) begin
            check("tx_hold_valid", tx_valid, 1);
            check("tx_hold_data", tx_data, tx_data_prev);
        end
        if (rst_n && tx_valid) check("rd_ready_in_send", read_ready, 0);
        if (rst_n && write_valid && write_ready) wr_q.push_back(write_data);
        if (rst_n && tx_valid && tx_ready) tx_q.push_back(tx_data);
        wr_wait_prev <= rst_n && write_valid && !write_ready;
        wr_data_prev <= write_data;
        tx_wait_prev <= rst_n && tx_valid && !tx_ready;
        tx_data_prev <= tx_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("rx_accept");
        step();
        rx_valid = 1'b0;
    endtask

    task automatic give_word(input logic [DATA_W-1:0] w);
        int n = 0;
        read_data  = w;
        read_valid = 1'b1;
        while (!read_ready && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("read_accept");
        step();
        read_valid = 1'b0;
    endtask

    task automatic wait_wr(input int cnt);
        int n = 0;
        while (wr_q.size() < cnt && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("write_count");
    endtask

    task automatic wait_tx(input int cnt);
        int n = 0;
        while (tx_q.size() < cnt && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("tx_count");
    endtask

    // Only meaningful once the last write of a burst has been handed off.
    task automatic wait_idle();
        int n = 0;
        while (!(rx_ready && !write_valid && !tx_valid && !read_ready) && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("idle");
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_reg_sel"}, reg_select, 0);
        check({tag, "_wr_valid"}, write_valid, 0);
        check({tag, "_wr_data"}, write_data, 0);
        check({tag, "_rd_ready"}, read_ready, 0);
    endtask

    task automatic check_ack(input string tag, input logic [7:0] cmd);
`ifdef STB_HOST_ADAPTER_ACK_EN
        wait_tx(1);
        check({tag, "_ack_count"}, tx_q.size(), 1);
        if (tx_q.size() > 0) check({tag, "_ack_byte"}, tx_q[0], cmd);
`else
        check({tag, "_no_tx"}, tx_q.size(), 0);
        check({tag, "_cmd_unused"}, cmd, cmd & 8'hFF);
`endif
    endtask

    initial begin
        logic [7:0]        exp_bytes[8];
        logic [DATA_W-1:0] exp_word;
        int                base;

        rst_n       = 1'b0;
        rx_data     = '0;
        rx_valid    = 1'b0;
        write_ready = 1'b1;
        read_data   = '0;
        read_valid  = 1'b0;

        // Reset state.
        repeat (3) step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();
        check("post_reset_rx_ready", rx_ready, 1);

        // 1: single-word write to the data register.
        send_byte(8'h80);
        check("wr1_reg_sel", reg_select, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("wr1_latency_valid", write_valid, 1);
        check("wr1_rx_ready_low", rx_ready, 0);
        check("wr1_data", write_data, 32'h4433_2211);
        wait_wr(1);
        wait_idle();
        check("wr1_count", wr_q.size(), 1);
        if (wr_q.size() > 0) check("wr1_word", wr_q[0], 32'h4433_2211);
        check_ack("wr1", 8'h80);
        wr_q.delete();
        tx_q.delete();

        // 2: two-word read burst from the config register.
        send_byte(8'h41);
        check("rd2_reg_sel", reg_select, 1);
        check("rd2_read_ready", read_ready, 1);
        check("rd2_rx_ready_low", rx_ready, 0);
        give_word(32'hDEAD_BEEF);
        check("rd2_latency_tx_valid", tx_valid, 1);
        check("rd2_read_ready_drop", read_ready, 0);
        check("rd2_first_byte", tx_data, 8'hEF);
        give_word(32'h0102_0304);
        wait_tx(8);
        check("rd2_reg_sel_hold", reg_select, 1);
        exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
        check("rd2_tx_count", tx_q.size(), 8);
        for (int i = 0; i < 8 && i < tx_q.size(); i++) check($sformatf("rd2_tx%0d", i), tx_q[i], exp_bytes[i]);
        step();
        check("rd2_idle_rx_ready", rx_ready, 1);
        check("rd2_idle_read_ready", read_ready, 0);
        tx_q.delete();

        // 3: write backpressure, then read with toggling TX ready.
        write_ready = 1'b0;
        send_byte(8'h81);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_rx_ready_low%0d", i), rx_ready, 0);
            step();
        end
        write_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send_byte(8'(i));
        wait_wr(2);
        wait_idle();
        check("bp_wr_count", wr_q.size(), 2);
        if (wr_q.size() > 1) begin
            check("bp_word0", wr_q[0], 32'h0403_0201);
            check("bp_word1", wr_q[1], 32'h0807_0605);
        end
        check_ack("bp", 8'h81);
        wr_q.delete();
        tx_q.delete();
        tx_mode = 1;
        send_byte(8'h00);
        check("bp_rd_reg_sel", reg_select, 0);
        give_word(32'hCAFE_F00D);
        wait_tx(4);
        tx_mode = 0;
        exp_bytes[0:3] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        check("bp_tx_count", tx_q.size(), 4);
        for (int i = 0; i < 4 && i < tx_q.size(); i++) check($sformatf("bp_tx%0d", i), tx_q[i], exp_bytes[i]);
        repeat (2) step();
        check("bp_no_extra_tx", tx_q.size(), 4);
        tx_q.delete();

        // 4: maximum burst, 64 words from count field 0x3F.
        send_byte(8'hBF);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        wait_wr(64);
        wait_idle();
        repeat (3) step();
        check("max_wr_count", wr_q.size(), 64);
        for (int k = 0; k < 64 && k < wr_q.size(); k++) begin
            base     = 4 * k;
            exp_word = {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
            check($sformatf("max_word%0d", k), wr_q[k], exp_word);
        end
        check("max_reg_sel", reg_select, 0);
        check_ack("max", 8'hBF);
        wr_q.delete();
        tx_q.delete();
        // A read command must be taken as a command, proving the burst ended.
        send_byte(8'h00);
        check("max_then_read_ready", read_ready, 1);
        give_word(32'h1122_3344);
        wait_tx(4);
        check("max_then_read_byte0", tx_q.size() > 0 ? tx_q[0] : 8'hXX, 8'h44);
        step();
        tx_q.delete();

        // 5: reset in the middle of a write burst.
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("midrst_no_write", wr_q.size(), 0);
        send_byte(8'h80);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_wr(1);
        wait_idle();
        check("midrst_wr_count", wr_q.size(), 1);
        if (wr_q.size() > 0) check("midrst_word", wr_q[0], 32'hDDCC_BBAA);
        check_ack("midrst", 8'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
